lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR, successor to the fixed 7-bit generator; width and tap mask set by parameter.
- Adds an explicit seed-load strobe, measurement of the sequence period, a zero-seed guard, lockup detection and a period-overflow watchdog.
- Feeds pseudo-random patterns to game/test logic; `complete` marks each full traversal of the sequence.

Parameters:
- WIDTH, 7: register width, 3..16.
- TAPS, 7'b1100000: feedback tap mask (bit i set means out[i] is XORed into feedback). The default equals out[6]^out[5].
- DEFAULT_SEED, 7'b0000001: substitute seed when a zero seed is presented; must be nonzero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- enable  in  1  advance one step per cycle while high
- load  in  1  load `seed` this cycle; overrides `enable`
- seed  in  WIDTH  seed value, sampled on rst or load
- out  out  WIDTH  current LFSR state
- feedback  out  1  combinational ^(out & TAPS)
- complete  out  1  one-cycle pulse when the state returns to the stored seed
- period  out  WIDTH  length of the last completed period
- period_valid  out  1  period holds a measured value
- seed_err  out  1  sticky; last rst/load saw seed==0
- lockup  out  1  sticky; state reached all-zeros
- overflow  out  1  sticky; 2^WIDTH-1 steps elapsed with no return to seed

Behaviour:
- All state updates occur on the rising edge of clk. Priority order: rst > load > enable > hold.
- rst or load:
  - seed_reg and out take `seed`, or DEFAULT_SEED if seed==0.
  - seed_err is set to (seed==0).
  - step_cnt clears to 0, and complete clears to 0.
  - rst only: period, period_valid, lockup and overflow clear to 0.
  - load only: period and period_valid are retained; lockup and overflow clear to 0.
- Step (enable=1, no rst/load):
  - out <= {out[WIDTH-2:0], feedback}; new value is visible one cycle after the enable edge.
  - step_cnt (WIDTH bits) increments.
- Completion: if next_out == seed_reg on a step:
  - complete=1 for exactly that cycle;
  - period <= step_cnt+1, period_valid <= 1;
  - step_cnt <= 0.
- Lockup: if next_out == 0 on a step, lockup <= 1 (sticky). The register stays at zero; no auto-reseed.
- Overflow:
  - Condition: step_cnt == 2^WIDTH-1 on a step and next_out != seed_reg.
  - Action: overflow <= 1 (sticky); step_cnt saturates and complete never fires.
- enable=0: all registers hold and complete=0.
- Mid-run rst/load: the sequence restarts from the new seed the next cycle and no complete pulse is generated for the aborted run.
- load and enable high together: load wins and no step occurs that cycle.
- feedback is purely combinational from out; every other output is registered.
- Internal FSM:
  - RUN: normal stepping.
  - STUCK: entered on lockup or overflow; stepping continues, no complete pulses.
  - rst or load returns the FSM to RUN.

Test Plan:
- Basic step: default parameters; rst with seed=7'b1101001, then enable for 1 cycle → out=7'b1010010, feedback before step=0.
- Full period: default parameters, seed 7'b1101001, enable held → complete pulses once after exactly 127 steps with out=7'b1101001, period=127, period_valid=1. A second pulse follows 127 steps later.
- Zero seed: load=1 with seed=0 → out=7'b0000001, seed_err=1. A later load with seed=7'b0000101 → seed_err=0, out=7'b0000101.
- Priority and hold:
  - load and enable high with seed=7'b0001111 → out=7'b0001111 with no step.
  - enable low for 10 cycles → out unchanged and complete=0.
  - rst asserted mid-run after 50 steps → out=seed, step_cnt=0, period_valid=0.
- Lockup/overflow:
  - Setup: WIDTH=4, TAPS=4'b0011, seed=4'b1000, enable held.
  - One step later: out=0000, lockup=1.
  - After 15 steps: overflow=1; complete never asserted.
- Alternate width: WIDTH=4, TAPS=4'b1100, seed=4'b0001 → complete after 15 steps, period=15.

Source files
------------

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Parametrised Fibonacci LFSR. It supports seed loading and a
//            zero-seed guard, and it measures the sequence period. It also
//            raises sticky flags for lockup (all-zero state) and for
//            overflow (no return to seed within 2^WIDTH-1 steps).
// Ports    : clk          rising-edge clock
//            rst          synchronous active-high reset (also loads seed)
//            enable       advance one step per cycle
//            load         load seed this cycle (overrides enable)
//            seed         seed value, sampled on rst or load
//            out          current LFSR state
//            feedback     combinational ^(out & TAPS)
//            complete     one-cycle pulse when the state returns to the seed
//            period       length of the last completed period
//            period_valid period holds a measured value
//            seed_err     sticky, last rst/load presented seed==0
//            lockup       sticky, state reached all-zeros
//            overflow     sticky, 2^WIDTH-1 steps without return to seed
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
  parameter int               WIDTH        = 7,
  parameter logic [WIDTH-1:0] TAPS         = 7'b1100000,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 7'b0000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             feedback,
  output logic             complete,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             seed_err,
  output logic             lockup,
  output logic             overflow
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STUCK = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - ONE;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             complete_q, complete_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;
  logic             overflow_q, overflow_d;

  logic             w_seed_zero;
  logic [WIDTH-1:0] w_seed_eff;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  assign w_seed_zero = (seed == '0);
  assign w_seed_eff  = w_seed_zero ? DEFAULT_SEED : seed;
  assign w_fb        = ^(out_q & TAPS);
  assign w_next      = {out_q[WIDTH-2:0], w_fb};
  assign w_wrap      = (w_next == seed_q);

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pv_d       = pv_q;
    complete_d = 1'b0;
    seed_err_d = seed_err_q;
    lockup_d   = lockup_q;
    overflow_d = overflow_q;

    if (load) begin
      // Restart from the new seed; the previous measurement stays visible.
      out_d      = w_seed_eff;
      seed_d     = w_seed_eff;
      seed_err_d = w_seed_zero;
      cnt_d      = '0;
      lockup_d   = 1'b0;
      overflow_d = 1'b0;
      state_d    = RUN;
    end else if (enable) begin
      out_d = w_next;
      if (w_wrap && (state_q == RUN)) begin
        complete_d = 1'b1;
        period_d   = cnt_q + ONE;
        pv_d       = 1'b1;
        cnt_d      = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + ONE;
      end
      // The step that brings the count to 2^WIDTH-1 without wrapping
      // means the sequence cannot be maximal from this seed. Count then
      // saturates at CNT_MAX.
      if (!w_wrap && (cnt_q == CNT_LAST)) begin
        overflow_d = 1'b1;
        state_d    = STUCK;
      end
      if (w_next == '0) begin
        lockup_d = 1'b1;
        state_d  = STUCK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      out_q      <= w_seed_eff;
      seed_q     <= w_seed_eff;
      cnt_q      <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      complete_q <= 1'b0;
      seed_err_q <= w_seed_zero;
      lockup_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      complete_q <= complete_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
      overflow_q <= overflow_d;
    end
  end

  assign out          = out_q;
  assign feedback     = w_fb;
  assign complete     = complete_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign seed_err     = seed_err_q;
  assign lockup       = lockup_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_gen
// Purpose  : Self-checking bench for lfsr_gen. It uses a default 7-bit
//            instance, a 4-bit instance with a lockup-prone tap set, and a
//            4-bit maximal instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: default parameters
  logic       a_rst, a_load, a_en, a_fb, a_cmp, a_pv, a_err, a_lock, a_ovf;
  logic [6:0] a_seed, a_out, a_per;
  // Instance B: WIDTH=4, TAPS=0011 (locks up from 1000)
  logic       b_rst, b_load, b_en, b_fb, b_cmp, b_pv, b_err, b_lock, b_ovf;
  logic [3:0] b_seed, b_out, b_per;
  // Instance C: WIDTH=4, TAPS=1100 (maximal)
  logic       c_rst, c_load, c_en, c_fb, c_cmp, c_pv, c_err, c_lock, c_ovf;
  logic [3:0] c_seed, c_out, c_per;

  lfsr_gen u_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .load(a_load), .seed(a_seed),
    .out(a_out), .feedback(a_fb), .complete(a_cmp), .period(a_per),
    .period_valid(a_pv), .seed_err(a_err), .lockup(a_lock), .overflow(a_ovf)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .DEFAULT_SEED(4'b0001)) u_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .load(b_load), .seed(b_seed),
    .out(b_out), .feedback(b_fb), .complete(b_cmp), .period(b_per),
    .period_valid(b_pv), .seed_err(b_err), .lockup(b_lock), .overflow(b_ovf)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .DEFAULT_SEED(4'b0001)) u_c (
    .clk(clk), .rst(c_rst), .enable(c_en), .load(c_load), .seed(c_seed),
    .out(c_out), .feedback(c_fb), .complete(c_cmp), .period(c_per),
    .period_valid(c_pv), .seed_err(c_err), .lockup(c_lock), .overflow(c_ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic r, input logic l, input logic e, input logic [6:0] s);
    a_rst = r; a_load = l; a_en = e; a_seed = s;
  endtask

  // Next state of a 7-bit Fibonacci LFSR with taps x^7+x^6+1.
  function automatic int next7(input int x);
    return ((x * 2) + ($countones(x & 7'h60) % 2)) % 128;
  endfunction

  typedef struct {
    logic       r, l, e;
    logic [6:0] sd;
    logic [6:0] eo;
    logic       eerr;
  } vec_t;

  vec_t vt[8];

  // Reference model state for the random phase
  int m_out, m_seed, m_steps, m_per;
  bit m_pv, m_cmp, m_err, m_lock, m_ovf;

  initial begin
    int steps;
    bit seen;
    a_drive(1'b1, 1'b0, 1'b0, 7'b1101001);
    b_rst = 1'b1; b_load = 1'b0; b_en = 1'b0; b_seed = 4'b1000;
    c_rst = 1'b1; c_load = 1'b0; c_en = 1'b0; c_seed = 4'b0001;
    tick();

    // ---------------- table-driven vectors on instance A ----------------
    vt[0] = '{1'b1, 1'b0, 1'b0, 7'b1101001, 7'b1101001, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 7'b0000000, 7'b1010010, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 7'b0001111, 7'b0001111, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 7'b1111111, 7'b0001111, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 7'b0000000, 7'b0000001, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 7'b0000000, 7'b0000010, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 7'b0000101, 7'b0000101, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 7'b0000000, 7'b0001010, 1'b0};
    for (int i = 0; i < 8; i++) begin
      a_drive(vt[i].r, vt[i].l, vt[i].e, vt[i].sd);
      tick();
      chk($sformatf("vec%0d_out", i), a_out, vt[i].eo);
      chk($sformatf("vec%0d_seed_err", i), a_err, vt[i].eerr);
      chk($sformatf("vec%0d_complete", i), a_cmp, 0);
      if (i == 0) begin
        chk("reset_period_valid", a_pv, 0);
        chk("reset_lockup", a_lock, 0);
        chk("reset_overflow", a_ovf, 0);
        chk("feedback_before_step", a_fb, 0);
      end
    end

    // ---------------- full period, two traversals ----------------
    a_drive(1'b1, 1'b0, 1'b0, 7'b1101001);
    tick();
    a_drive(1'b0, 1'b0, 1'b1, 7'b0000000);
    for (int p = 0; p < 2; p++) begin
      steps = 0;
      do begin
        tick();
        steps++;
      end while (!a_cmp && steps < 200);
      chk($sformatf("period%0d_steps", p), steps, 127);
      chk($sformatf("period%0d_out", p), a_out, 7'b1101001);
      chk($sformatf("period%0d_len", p), a_per, 127);
      chk($sformatf("period%0d_valid", p), a_pv, 1);
    end
    tick();
    chk("complete_one_cycle", a_cmp, 0);

    // ---------------- hold for 10 cycles ----------------
    a_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out", a_out, next7(7'b1101001));
      chk("hold_complete", a_cmp, 0);
    end

    // ---------------- rst after 50 steps ----------------
    a_en = 1'b1;
    repeat (50) tick();
    a_drive(1'b1, 1'b0, 1'b1, 7'b0110011);
    tick();
    chk("midrst_out", a_out, 7'b0110011);
    chk("midrst_period_valid", a_pv, 0);
    chk("midrst_period", a_per, 0);
    a_drive(1'b0, 1'b0, 1'b1, 7'b0000000);
    steps = 0;
    do begin
      tick();
      steps++;
    end while (!a_cmp && steps < 200);
    chk("midrst_steps_to_complete", steps, 127);

    // load keeps the measured period
    repeat (20) tick();
    a_drive(1'b0, 1'b1, 1'b1, 7'b0001111);
    tick();
    chk("load_out", a_out, 7'b0001111);
    chk("load_keeps_period", a_per, 127);
    chk("load_keeps_valid", a_pv, 1);
    chk("load_no_complete", a_cmp, 0);

    // ---------------- lockup / overflow (instance B) ----------------
    b_rst = 1'b0; b_en = 1'b1;
    seen = 1'b0;
    tick();
    chk("b_lock_out", b_out, 0);
    chk("b_lockup", b_lock, 1);
    for (int i = 2; i <= 40; i++) begin
      tick();
      seen |= b_cmp;
      if (i == 14) chk("b_overflow_at14", b_ovf, 0);
      if (i == 15) chk("b_overflow_at15", b_ovf, 1);
    end
    chk("b_no_complete", seen, 0);
    chk("b_still_zero", b_out, 0);
    b_load = 1'b1; b_seed = 4'b0011;
    tick();
    chk("b_load_clears_lockup", b_lock, 0);
    chk("b_load_clears_overflow", b_ovf, 0);
    b_load = 1'b0; b_en = 1'b0;

    // ---------------- 4-bit maximal (instance C) ----------------
    c_rst = 1'b0; c_en = 1'b1;
    steps = 0;
    do begin
      tick();
      steps++;
    end while (!c_cmp && steps < 40);
    chk("c_steps", steps, 15);
    chk("c_period", c_per, 15);
    chk("c_period_valid", c_pv, 1);
    chk("c_out", c_out, 1);
    c_en = 1'b0;

    // ---------------- randomized vs model (instance A) ----------------
    a_drive(1'b1, 1'b0, 1'b0, 7'b1010101);
    tick();
    m_out = 7'b1010101; m_seed = m_out; m_steps = 0; m_per = 0;
    m_pv = 0; m_cmp = 0; m_err = 0; m_lock = 0; m_ovf = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int sd, eff, nxt;
      a_rst  = ($urandom_range(0, 199) == 0);
      a_load = ($urandom_range(0, 49) == 0);
      a_en   = ($urandom_range(0, 9) < 8);
      sd     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 127);
      a_seed = sd[6:0];
      eff    = (sd == 0) ? 1 : sd;
      m_cmp  = 0;
      if (a_rst || a_load) begin
        m_out = eff; m_seed = eff; m_err = (sd == 0); m_steps = 0;
        m_lock = 0; m_ovf = 0;
        if (a_rst) begin m_per = 0; m_pv = 0; end
      end else if (a_en) begin
        nxt = next7(m_out);
        m_steps++;
        if (nxt == m_seed && !m_lock && !m_ovf) begin
          m_cmp = 1; m_per = m_steps; m_pv = 1; m_steps = 0;
        end else if (m_steps >= 127 && nxt != m_seed) begin
          m_ovf = 1;
        end
        if (nxt == 0) m_lock = 1;
        m_out = nxt;
      end
      tick();
      chk("rnd_out", a_out, m_out);
      chk("rnd_feedback", a_fb, $countones(m_out & 7'h60) % 2);
      chk("rnd_complete", a_cmp, m_cmp);
      chk("rnd_period", a_per, m_per);
      chk("rnd_period_valid", a_pv, m_pv);
      chk("rnd_seed_err", a_err, m_err);
      chk("rnd_lockup", a_lock, m_lock);
      chk("rnd_overflow", a_ovf, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
